ysyx_22050550_imem_resp: RTL and testbench
==========================================

YSYX_22050550_IMEM_RESP -- requirements
Module: ysyx_22050550_imem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning width of fetch address (PC bus width).
REQ-002 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of the number of 32-bit words in the array.
REQ-003 SHALL have parameter BASE, default 64'h8000_0000, meaning byte address of word 0.
REQ-004 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to resp_valid; legal range 1..15.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL have port req_valid, input, 1, meaning the CPU presents a fetch address.
REQ-008 SHALL have port req_ready, output, 1, meaning the block can accept a fetch.
REQ-009 SHALL have port req_addr, input, ADDR_W, meaning the fetch byte address (PC).
REQ-010 SHALL have port resp_valid, output, 1, meaning resp_inst/resp_err are valid.
REQ-011 SHALL have port resp_ready, input, 1, meaning the CPU consumes the response.
REQ-012 SHALL have port resp_inst, output, 32, meaning the fetched instruction.
REQ-013 SHALL have port resp_err, output, 1, meaning the fetch was misaligned or out of range.
REQ-014 SHALL have port wr_en, input, 1, meaning backdoor array write (image preload).
REQ-015 SHALL have port wr_addr, input, DEPTH_LOG2, meaning the word index for the backdoor write.
REQ-016 SHALL have port wr_data, input, 32, meaning the backdoor write data.

Function
REQ-017 SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE; WAIT is skipped (IDLE -> RESP) when LATENCY=1.
REQ-018 SHALL drive req_ready=1 only in IDLE; accept = req_valid & req_ready.
REQ-019 SHALL latch req_addr on accept, load the latency counter with LATENCY-1, and leave IDLE.
REQ-020 SHALL, in WAIT, decrement the counter each cycle and enter RESP on the edge where it reaches 0, so resp_valid first rises exactly LATENCY cycles after the accept edge.
REQ-021 SHALL drive resp_valid=1 only in RESP, and hold resp_inst/resp_err stable until resp_valid & resp_ready.
REQ-022 SHALL return to IDLE on the response handshake; req_ready rises the following cycle; with no back-to-back accept, one fetch completes per LATENCY+1 cycles minimum.
REQ-023 SHALL flag error when addr[1:0]!=0 or when addr<BASE or addr>=BASE+4*2^DEPTH_LOG2; an error response has resp_err=1 and resp_inst=32'h0.
REQ-024 SHALL compute the word index as (addr-BASE)>>2, truncated to DEPTH_LOG2 bits, only for in-range addresses.
REQ-025 SHALL sample the array into the resp_inst register on the edge entering RESP; a wr_en to the same word on that same edge yields the pre-write contents (read-old).
REQ-026 SHALL accept a wr_en in any state; an array write does not change an already-latched response.
REQ-027 SHALL ignore req_valid and req_addr changes while not in IDLE.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, force IDLE, counter=0, resp_valid=0, resp_err=0, resp_inst=32'h0, and req_ready=1 in the following cycle.
REQ-029 SHALL drop any in-flight request on reset mid-WAIT or mid-RESP, with no response delivered afterwards.
REQ-030 SHALL leave array contents unchanged by reset; a wr_en asserted with rst=1 still writes.

Verification
REQ-031 SHALL cover: preload word 0=32'h00100093, LATENCY=2, fetch 0x8000_0000 with resp_ready=1 -> resp_valid rises 2 cycles after accept, resp_inst=32'h00100093, resp_err=0.
REQ-032 SHALL cover: resp_ready held 0 for 5 cycles in RESP -> resp_valid and resp_inst stable throughout, req_ready=0, a second req_valid ignored.
REQ-033 SHALL cover: fetch 0x8000_0002 and fetch 0x7FFF_FFFC and fetch BASE+0x4000 -> each resp_err=1, resp_inst=0.
REQ-034 SHALL cover: wr_en to word 3 with 32'hDEADBEEF on the edge entering RESP for a fetch of 0x8000_000C (old value 32'h00000013) -> resp_inst=32'h00000013; next fetch of the same address returns 32'hDEADBEEF.
REQ-035 SHALL cover: rst asserted one cycle after accept -> next cycle req_ready=1, resp_valid stays 0, no stale response appears.
REQ-036 SHALL cover: LATENCY=1 build, back-to-back fetches 0x8000_0000/0x8000_0004 with resp_ready=1 -> resp_valid one cycle after each accept, accepts 2 cycles apart.

Source files
------------

// File: rtl/ysyx_22050550_imem_resp.sv
// ysyx_22050550_imem_resp
// Instruction-memory responder for a fetch unit. A word-addressed array of
// 32-bit instructions is read after a fixed, parameterised latency using a
// valid/ready handshake on both the request and the response side. Fetches
// that are misaligned or outside [BASE, BASE + 4*2^DEPTH_LOG2) complete with
// resp_err=1 and a zero instruction. A backdoor write port preloads the image.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : fetch request handshake (ready only when idle)
//   req_addr  [ADDR_W]    : fetch byte address (PC)
//   resp_valid/resp_ready : response handshake
//   resp_inst [32]        : fetched instruction (0 on error)
//   resp_err              : misaligned or out-of-range fetch
//   wr_en/wr_addr/wr_data : backdoor array write, honoured in every state
module ysyx_22050550_imem_resp #(
  parameter int          ADDR_W     = 64,
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_inst,
  output logic                  resp_err,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  // Range bounds are one bit wider than the address so BASE + span cannot wrap.
  localparam logic [ADDR_W:0] BASE_X   = (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0] SPAN     = (ADDR_W+1)'(4) << DEPTH_LOG2;
  localparam logic [ADDR_W:0] LIMIT    = BASE_X + SPAN;
  localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

  logic [31:0]           mem_q [2**DEPTH_LOG2];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [31:0]           inst_q;
  logic                  err_q;
  logic                  load_resp;

  logic [ADDR_W-1:0]     rd_addr;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_err;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_inst  = inst_q;
  assign resp_err   = err_q;

  // Backdoor write port; no reset so a preload issued under rst still lands.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // With LATENCY=1 the array is sampled on the accept edge itself, so the
  // read address must come straight from the request bus while idle.
  always_comb begin
    rd_addr = (state_q == S_IDLE) ? req_addr : addr_q;
    rd_idx  = DEPTH_LOG2'((rd_addr - BASE_X[ADDR_W-1:0]) >> 2);
    rd_err  = (rd_addr[1:0] != 2'b00) ||
              ({1'b0, rd_addr} < BASE_X) ||
              ({1'b0, rd_addr} >= LIMIT);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    load_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          cnt_d  = CNT_INIT;
          if (CNT_INIT == 4'd0) begin
            state_d   = S_RESP;
            load_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Leave on the edge where the count hits zero.
        if (cnt_q <= 4'd1) begin
          state_d   = S_RESP;
          load_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- stage boundary: request/state registers ----
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      inst_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Nonblocking array read gives pre-write data on a same-edge write.
      if (load_resp) begin
        err_q  <= rd_err;
        inst_q <= rd_err ? 32'h0 : mem_q[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050550_imem_resp.sv
module tb_ysyx_22050550_imem_resp;
  localparam int AW = 64;
  localparam int DL = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DL-1:0] wr_addr;
  logic [31:0]   wr_data;

  logic          a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_resp_err;
  logic [AW-1:0] a_req_addr;
  logic [31:0]   a_resp_inst;
  logic          b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err;
  logic [AW-1:0] b_req_addr;
  logic [31:0]   b_resp_inst;

  always #5 clk = ~clk;

  ysyx_22050550_imem_resp #(
    .ADDR_W(AW), .DEPTH_LOG2(DL), .BASE(64'h8000_0000), .LATENCY(2)
  ) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_inst(a_resp_inst), .resp_err(a_resp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  ysyx_22050550_imem_resp #(
    .ADDR_W(AW), .DEPTH_LOG2(DL), .BASE(64'h8000_0000), .LATENCY(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_inst(b_resp_inst), .resp_err(b_resp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [DL-1:0] idx, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = idx;
    wr_data = data;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  // One fetch on the LATENCY=2 instance. Called at posedge+1 with DUT idle.
  // hold: cycles resp_ready is held low in RESP; wr_old: write word 3 on the
  // edge that enters RESP.
  task automatic fetch_a(input logic [63:0] addr, input logic [31:0] e_inst,
                         input logic e_err, input int hold, input bit wr_old);
    int   k;
    exp_t e;
    k = 0;
    while (!a_req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("req_ready_idle", a_req_ready, 1);
    a_req_valid = 1'b1;
    a_req_addr  = addr;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    e.inst = e_inst;
    e.err  = e_err;
    sb.push_back(e);
    if (wr_old) begin
      wr_en   = 1'b1;
      wr_addr = 12'd3;
      wr_data = 32'hDEADBEEF;
    end
    k = 1;
    while (!a_resp_valid && k < 20) begin
      @(posedge clk); #1;
      wr_en = 1'b0;
      k++;
    end
    chk("latency", k, 2);
    chk("resp_valid", a_resp_valid, 1);
    for (int i = 0; i < hold; i++) begin
      a_req_valid = 1'b1;
      a_req_addr  = addr + 64'd4;
      if (i == 1) begin
        wr_en   = 1'b1;
        wr_addr = 12'd1;
        wr_data = 32'h22222222;
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      chk("hold_valid", a_resp_valid, 1);
      chk("hold_inst", a_resp_inst, sb[0].inst);
      chk("hold_req_ready", a_req_ready, 0);
    end
    a_req_valid  = 1'b0;
    a_resp_ready = 1'b1;
    e = sb.pop_front();
    chk("resp_inst", a_resp_inst, e.inst);
    chk("resp_err", a_resp_err, e.err);
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
    chk("resp_drop", a_resp_valid, 0);
    chk("req_ready_after", a_req_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    a_req_valid = 1'b0; a_req_addr = '0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b1;

    vecs[0] = '{64'h8000_0000, 32'h00100093, 1'b0};
    vecs[1] = '{64'h8000_0004, 32'h11111111, 1'b0};
    vecs[2] = '{64'h8000_000C, 32'h00000013, 1'b0};
    vecs[3] = '{64'h8000_3FFC, 32'hCAFE0FFF, 1'b0};
    vecs[4] = '{64'h8000_0002, 32'h0, 1'b1};
    vecs[5] = '{64'h7FFF_FFFC, 32'h0, 1'b1};
    vecs[6] = '{64'h8000_4000, 32'h0, 1'b1};
    vecs[7] = '{64'h1_8000_0000, 32'h0, 1'b1};

    // Preload while still in reset: writes must land regardless.
    @(posedge clk); #1;
    write_word(12'd0, 32'h00100093);
    write_word(12'd1, 32'h11111111);
    write_word(12'd3, 32'h00000013);
    write_word(12'd4095, 32'hCAFE0FFF);
    rst = 1'b0;

    chk("rst_req_ready", a_req_ready, 1);
    chk("rst_resp_valid", a_resp_valid, 0);
    chk("rst_resp_err", a_resp_err, 0);
    chk("rst_resp_inst", a_resp_inst, 0);
    chk("rst_b_req_ready", b_req_ready, 1);

    // LATENCY=1: back-to-back fetches, resp_ready held high.
    b_req_valid = 1'b1;
    b_req_addr  = 64'h8000_0000;
    chk("b_ready0", b_req_ready, 1);
    @(posedge clk); #1;
    chk("b_valid0", b_resp_valid, 1);
    chk("b_inst0", b_resp_inst, 32'h00100093);
    chk("b_busy0", b_req_ready, 0);
    b_req_addr = 64'h8000_0004;
    @(posedge clk); #1;
    chk("b_gap_valid", b_resp_valid, 0);
    chk("b_ready1", b_req_ready, 1);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    chk("b_valid1", b_resp_valid, 1);
    chk("b_inst1", b_resp_inst, 32'h11111111);
    chk("b_err1", b_resp_err, 0);
    @(posedge clk); #1;
    chk("b_done", b_resp_valid, 0);

    for (int i = 0; i < 8; i++)
      fetch_a(vecs[i].addr, vecs[i].inst, vecs[i].err, 0, 1'b0);

    // Same-edge write returns old data; the following fetch sees the new word.
    fetch_a(64'h8000_000C, 32'h00000013, 1'b0, 0, 1'b1);
    fetch_a(64'h8000_000C, 32'hDEADBEEF, 1'b0, 0, 1'b0);

    // Backpressure for 5 cycles with a stray request and an array write.
    fetch_a(64'h8000_0004, 32'h11111111, 1'b0, 5, 1'b0);
    fetch_a(64'h8000_0004, 32'h22222222, 1'b0, 0, 1'b0);

    // Reset one cycle after accept (mid-WAIT).
    a_req_valid = 1'b1;
    a_req_addr  = 64'h8000_0000;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstw_req_ready", a_req_ready, 1);
    chk("rstw_resp_valid", a_resp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rstw_no_stale", a_resp_valid, 0);
    end

    // Reset while a response is pending (mid-RESP).
    a_req_valid = 1'b1;
    a_req_addr  = 64'h8000_0000;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstr_pre_valid", a_resp_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstr_resp_valid", a_resp_valid, 0);
    chk("rstr_resp_inst", a_resp_inst, 0);
    chk("rstr_resp_err", a_resp_err, 0);
    chk("rstr_req_ready", a_req_ready, 1);
    @(posedge clk); #1;
    chk("rstr_no_stale", a_resp_valid, 0);

    fetch_a(64'h8000_0000, 32'h00100093, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
